bit_population_generator: RTL and testbench
===========================================

Name: bit_population_generator

Overview:
- Inverse direction of the pipelined population counter: accepts a requested ones-count and emits a WIDTH-bit word containing exactly that many set bits.
- Serves as a stimulus source and loopback partner for the counter. Its data_o/data_val_o connect directly to the counter's data_i/data_val_i.
- Bits are placed one position per cycle by a serial state machine. Placement is LSB-packed or pseudo-random; see Optional Feature.

Parameters:
- WIDTH, 8, output word width in bits; must be >= 2.
- SEED, 16'hACE1, initial 16-bit LFSR state; 0 is replaced by 16'h0001.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous active-high reset.
- cnt_i  input  $clog2(WIDTH)+1  requested number of ones.
- cnt_val_i  input  1  cnt_i valid.
- cnt_ready_o  output  1  block can accept a request.
- data_o  output  WIDTH  generated word.
- data_val_o  output  1  one-cycle pulse, data_o valid.

Behaviour:
- Clock and reset: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values:
  - state = IDLE
  - cnt_ready_o = 1
  - data_o = 0
  - data_val_o = 0
  - LFSR = SEED (or 1 if SEED = 0)
  - internal remaining-ones, position and shift register = 0
- States:
  - IDLE: cnt_ready_o = 1. A handshake (cnt_val_i & cnt_ready_o) latches rem_ones = min(cnt_i, WIDTH) and sets pos = 0, work = 0, then goes to FILL. No handshake: stay in IDLE.
  - FILL: cnt_ready_o = 0. Each cycle decides bit work[pos]:
    - set the bit if rem_ones == WIDTH - pos (forced), or if rem_ones > 0 and the placement rule allows it;
    - on a set, rem_ones decrements;
    - pos increments;
    - after pos == WIDTH-1 is processed, go to DONE.
  - DONE: data_o <= work; data_val_o = 1 for exactly this cycle; cnt_ready_o = 0; next state is IDLE.
- Latency and throughput:
  - Handshake at cycle T gives data_val_o high at T+WIDTH+1.
  - Throughput is one word per WIDTH+2 cycles.
  - cnt_val_i asserted while cnt_ready_o = 0 is ignored; the requester holds it until accepted.
- data_o holds its last value between pulses and is meaningful only while data_val_o = 1.
- Clamping: cnt_i > WIDTH is treated as WIDTH, giving an all-ones output. cnt_i = 0 gives an all-zero word, still pulsed after full latency.
- Invariant: popcount(data_o) == min(cnt_i, WIDTH) for every pulse, in both placement modes.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clock in every state except during reset.
- Reset mid-FILL or mid-DONE:
  - request aborts; no data_val_o pulse;
  - the next cycle is in IDLE with cnt_ready_o = 1;
  - the LFSR reloads SEED.

Optional Feature:
- Macro BIT_POP_GEN_RANDOM_EN.
- Defined: the placement rule allows a set when LFSR[0] = 1. This gives pseudo-random bit positions; the forced rule still guarantees the exact count.
- Undefined: the placement rule always allows a set, so ones are packed from the LSB (thermometer code, e.g. cnt 3 -> 8'b0000_0111). The LFSR is not instantiated.
- Latency is identical in both builds.

Decomposition:
- Package bit_pop_pkg holds:
  - state typedef enum {IDLE, FILL, DONE};
  - LFSR width constant (16);
  - tap mask constant 16'hB400;
  - SEED fallback constant.
- Sub-module lfsr16 (clk_i, srst_i, seed, state output), instantiated only under BIT_POP_GEN_RANDOM_EN.

Test Plan:
- WIDTH=8, macro off, cnt_i=3 pulsed at cycle 10 -> data_val_o at cycle 19 with data_o=8'h07; cnt_ready_o low in cycles 11..19.
- WIDTH=8, cnt_i=0 and then cnt_i=15 -> 8'h00, then 8'hFF (clamped); each is a single-cycle pulse.
- WIDTH=16, macro on, sweep cnt_i 0..16 with 200 random requests looped into bit_population_counter -> counter output equals min(cnt_i,16) every time; at least two distinct patterns observed for cnt_i=8.
- cnt_val_i held high continuously, WIDTH=8 -> accepts occur every 10 cycles; no request is lost or duplicated.
- srst_i asserted 4 cycles into FILL -> no data_val_o pulse; cnt_ready_o=1 on the cycle after reset deasserts; the next request (cnt_i=5) completes correctly.
- Macro on, same SEED, same request sequence after two resets -> identical data_o sequences.

Source files
------------

// File: rtl/bit_pop_pkg.sv
// Shared types and constants for the bit population generator and its LFSR.
package bit_pop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          LFSR_W        = 16;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] SEED_FALLBACK = 16'h0001;

   // Galois step for x^16+x^14+x^13+x^11, shifting toward bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ LFSR_TAPS;
      end
      return n;
   endfunction

   // An all-zero seed would lock the LFSR, so it is swapped for a safe value.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? SEED_FALLBACK : s;
   endfunction

endpackage

// File: rtl/bit_population_generator_lfsr16.sv
// 16-bit Galois LFSR used for random bit placement; present only when
// BIT_POP_GEN_RANDOM_EN is defined.
`ifdef BIT_POP_GEN_RANDOM_EN
module lfsr16
   import bit_pop_pkg::*;
(
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [LFSR_W-1:0] state_o
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   always_comb begin
      state_d = lfsr_next(state_q);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= seed_fix(seed_i);
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule
`endif

// File: rtl/bit_population_generator.sv
// Emits a WIDTH-bit word holding exactly min(cnt_i, WIDTH) ones, one bit per cycle.
// Define BIT_POP_GEN_RANDOM_EN for LFSR-driven placement; otherwise ones pack from the LSB.
module bit_population_generator
   import bit_pop_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic [$clog2(WIDTH):0]   cnt_i,
   input  logic                     cnt_val_i,
   output logic                     cnt_ready_o,
   output logic [WIDTH-1:0]         data_o,
   output logic                     data_val_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = $clog2(WIDTH);
   localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);

   state_t           state_q;
   logic             ready_q;
   logic [WIDTH-1:0] data_q;
   logic             data_val_q;
   logic [CW-1:0]    rem_q;
   logic [CW-1:0]    rem_d;
   logic [PW-1:0]    pos_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_d;

   logic             place_allow;
   logic             force_set;
   logic             set_bit;
   logic [CW-1:0]    slots_left;
   logic [CW-1:0]    cnt_clamped;

`ifdef BIT_POP_GEN_RANDOM_EN
   logic [LFSR_W-1:0] lfsr_state;
   logic              unused_lfsr_bits;

   lfsr16 u_lfsr (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .seed_i  (SEED),
      .state_o (lfsr_state)
   );

   assign place_allow      = lfsr_state[0];
   assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:1];
`else
   localparam logic [15:0] UNUSED_SEED = SEED;
   assign place_allow = 1'b1;
`endif

   assign cnt_clamped = (int'(cnt_i) > WIDTH) ? CW'(WIDTH) : cnt_i;

   // A bit is forced when the ones still owed exactly fill the remaining slots.
   always_comb begin
      slots_left    = CW'(WIDTH) - CW'(pos_q);
      force_set     = (rem_q == slots_left);
      set_bit       = force_set || ((rem_q != '0) && place_allow);
      work_d        = work_q;
      work_d[pos_q] = set_bit;
      rem_d         = set_bit ? (rem_q - CW'(1)) : rem_q;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         data_q     <= '0;
         data_val_q <= 1'b0;
         rem_q      <= '0;
         pos_q      <= '0;
         work_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cnt_val_i && ready_q) begin
                  rem_q   <= cnt_clamped;
                  pos_q   <= '0;
                  work_q  <= '0;
                  ready_q <= 1'b0;
                  state_q <= FILL;
               end
            end
            FILL: begin
               work_q <= work_d;
               rem_q  <= rem_d;
               pos_q  <= pos_q + PW'(1);
               // The finished word is registered on the way into DONE so the
               // pulse and the data appear together in that cycle.
               if (pos_q == POS_LAST) begin
                  data_q     <= work_d;
                  data_val_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               data_val_q <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               data_val_q <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign cnt_ready_o = ready_q;
   assign data_o      = data_q;
   assign data_val_o  = data_val_q;

endmodule

// File: tb/tb_bit_population_generator.sv
// Randomized self-checking bench for bit_population_generator (WIDTH 8 and 16 instances);
// expectations come from a popcount/thermometer model of the requested count.
`timescale 1ns/1ps
module tb_bit_population_generator;

   logic        clk;
   logic        srst;
   logic [3:0]  cnt8;
   logic        val8;
   logic        rdy8;
   logic [7:0]  d8;
   logic        dv8;
   logic [4:0]  cnt16;
   logic        val16;
   logic        rdy16;
   logic [15:0] d16;
   logic        dv16;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bit_population_generator #(.WIDTH(8)) dut8 (
      .clk_i(clk), .srst_i(srst), .cnt_i(cnt8), .cnt_val_i(val8),
      .cnt_ready_o(rdy8), .data_o(d8), .data_val_o(dv8)
   );

   bit_population_generator #(.WIDTH(16)) dut16 (
      .clk_i(clk), .srst_i(srst), .cnt_i(cnt16), .cnt_val_i(val16),
      .cnt_ready_o(rdy16), .data_o(d16), .data_val_o(dv16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int exp_ones(input int c, input int w);
      return (c > w) ? w : c;
   endfunction

   function automatic logic [15:0] thermo(input int n);
      logic [31:0] t;
      t = (32'd1 << n) - 32'd1;
      return t[15:0];
   endfunction

   task automatic do_reset();
      srst  = 1'b1;
      val8  = 1'b0;
      val16 = 1'b0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
   endtask

   task automatic req8(input int c, output logic [7:0] d, output int lat,
                       output logic dv_after, output logic rdy_bad);
      int n;
      n = 0;
      while (rdy8 !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL req8_ready_wait got=%b expected=1", rdy8);
      end
      cnt8 = 4'(c);
      val8 = 1'b1;
      @(posedge clk); #1;
      val8 = 1'b0;
      lat = -1; d = '0; rdy_bad = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rdy8 !== 1'b0) rdy_bad = 1'b1;
         if (dv8 === 1'b1) begin
            lat = k; d = d8;
            break;
         end
      end
      @(negedge clk);
      dv_after = dv8;
      $display("req8  cnt=%0d data=%b latency=%0d", c, d, lat);
      @(posedge clk); #1;
   endtask

   task automatic req16(input int c, output logic [15:0] d, output int lat,
                        output logic dv_after);
      int n;
      n = 0;
      while (rdy16 !== 1'b1 && n < 80) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 80) begin
         errors++;
         $display("FAIL req16_ready_wait got=%b expected=1", rdy16);
      end
      cnt16 = 5'(c);
      val16 = 1'b1;
      @(posedge clk); #1;
      val16 = 1'b0;
      lat = -1; d = '0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (dv16 === 1'b1) begin
            lat = k; d = d16;
            break;
         end
      end
      @(negedge clk);
      dv_after = dv16;
      $display("req16 cnt=%0d data=%b latency=%0d", c, d, lat);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks += 6;
      if (rdy8 !== 1'b1)   begin errors++; $display("FAIL reset_rdy8 got=%b expected=1", rdy8); end
      if (dv8 !== 1'b0)    begin errors++; $display("FAIL reset_dv8 got=%b expected=0", dv8); end
      if (d8 !== 8'h00)    begin errors++; $display("FAIL reset_d8 got=%h expected=00", d8); end
      if (rdy16 !== 1'b1)  begin errors++; $display("FAIL reset_rdy16 got=%b expected=1", rdy16); end
      if (dv16 !== 1'b0)   begin errors++; $display("FAIL reset_dv16 got=%b expected=0", dv16); end
      if (d16 !== 16'h0)   begin errors++; $display("FAIL reset_d16 got=%h expected=0000", d16); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic [7:0]  d;
      logic [15:0] e;
      int          lat;
      logic        dva, rb;
      req8(3, d, lat, dva, rb);
      e = thermo(3);
      checks += 4;
      if (lat !== 9)    begin errors++; $display("FAIL latency_cnt3 got=%0d expected=9", lat); end
      if (rb !== 1'b0)  begin errors++; $display("FAIL latency_ready_low got_high=%b expected=0", rb); end
      if (dva !== 1'b0) begin errors++; $display("FAIL latency_pulse_width got=%b expected=0", dva); end
      if ($countones(d) !== 3) begin errors++; $display("FAIL latency_popcount got=%0d expected=3", $countones(d)); end
`ifndef BIT_POP_GEN_RANDOM_EN
      checks++;
      if (d !== e[7:0]) begin errors++; $display("FAIL latency_word got=%h expected=%h", d, e[7:0]); end
`endif
   endtask

   task automatic test_clamp();
      logic [7:0] d;
      int         lat;
      logic       dva, rb;
      req8(0, d, lat, dva, rb);
      checks += 3;
      if (d !== 8'h00)  begin errors++; $display("FAIL clamp_zero_word got=%h expected=00", d); end
      if (lat !== 9)    begin errors++; $display("FAIL clamp_zero_latency got=%0d expected=9", lat); end
      if (dva !== 1'b0) begin errors++; $display("FAIL clamp_zero_pulse got=%b expected=0", dva); end
      req8(15, d, lat, dva, rb);
      checks += 3;
      if (d !== 8'hFF)  begin errors++; $display("FAIL clamp_max_word got=%h expected=ff", d); end
      if (lat !== 9)    begin errors++; $display("FAIL clamp_max_latency got=%0d expected=9", lat); end
      if (dva !== 1'b0) begin errors++; $display("FAIL clamp_max_pulse got=%b expected=0", dva); end
   endtask

   task automatic test_back_to_back();
      int   expq[$];
      int   acc[$];
      int   e;
      logic chg;
      logic [15:0] t;
      cnt8 = 4'($urandom_range(0, 15));
      val8 = 1'b1;
      for (int i = 0; i < 120; i++) begin
         chg = 1'b0;
         @(negedge clk);
         if (val8 && rdy8) begin
            expq.push_back(int'(cnt8));
            acc.push_back(cyc);
            chg = 1'b1;
         end
         if (dv8 === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected_pulse got=%h expected=no_pulse", d8);
            end else begin
               e = expq.pop_front();
               t = thermo(exp_ones(e, 8));
               $display("b2b   cnt=%0d data=%b", e, d8);
               if ($countones(d8) !== exp_ones(e, 8)) begin
                  errors++; $display("FAIL b2b_popcount got=%0d expected=%0d", $countones(d8), exp_ones(e, 8));
               end
`ifndef BIT_POP_GEN_RANDOM_EN
               else if (d8 !== t[7:0]) begin
                  errors++; $display("FAIL b2b_word got=%h expected=%h", d8, t[7:0]);
               end
`endif
            end
         end
         @(posedge clk); #1;
         if (chg) cnt8 = 4'($urandom_range(0, 15));
         if (i == 100) val8 = 1'b0;
      end
      checks += 2;
      if (expq.size() != 0) begin errors++; $display("FAIL b2b_lost_requests got=%0d expected=0", expq.size()); end
      if (acc.size() != 11) begin errors++; $display("FAIL b2b_accept_count got=%0d expected=11", acc.size()); end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] != 10) begin
            errors++; $display("FAIL b2b_interval got=%0d expected=10", acc[i] - acc[i-1]);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [7:0]  d;
      logic [15:0] e;
      int          lat, pulses;
      logic        dva, rb;
      cnt8 = 4'd5;
      val8 = 1'b1;
      @(posedge clk); #1;
      val8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      @(negedge clk);
      checks += 2;
      if (rdy8 !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b expected=1", rdy8); end
      pulses = (dv8 === 1'b1) ? 1 : 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (dv8 === 1'b1) pulses++;
      end
      if (pulses != 0) begin errors++; $display("FAIL midreset_pulse got=%0d expected=0", pulses); end
      @(posedge clk); #1;
      req8(5, d, lat, dva, rb);
      e = thermo(5);
      checks += 2;
      if ($countones(d) !== 5) begin errors++; $display("FAIL midreset_next_popcount got=%0d expected=5", $countones(d)); end
      if (lat !== 9) begin errors++; $display("FAIL midreset_next_latency got=%0d expected=9", lat); end
`ifndef BIT_POP_GEN_RANDOM_EN
      checks++;
      if (d !== e[7:0]) begin errors++; $display("FAIL midreset_next_word got=%h expected=%h", d, e[7:0]); end
`endif
   endtask

   task automatic test_sweep16();
      logic [15:0] d, t, first8;
      int          lat, c, n8;
      logic        dva, distinct;
      n8 = 0; distinct = 1'b0; first8 = '0;
      for (int i = 0; i < 200; i++) begin
         if (i <= 16)          c = i;
         else if (i % 20 == 19) c = 8;
         else                  c = $urandom_range(0, 31);
         req16(c, d, lat, dva);
         t = thermo(exp_ones(c, 16));
         checks += 3;
         if ($countones(d) !== exp_ones(c, 16)) begin
            errors++; $display("FAIL sweep_popcount cnt=%0d got=%0d expected=%0d", c, $countones(d), exp_ones(c, 16));
         end
         if (lat !== 17)   begin errors++; $display("FAIL sweep_latency got=%0d expected=17", lat); end
         if (dva !== 1'b0) begin errors++; $display("FAIL sweep_pulse got=%b expected=0", dva); end
`ifndef BIT_POP_GEN_RANDOM_EN
         checks++;
         if (d !== t) begin errors++; $display("FAIL sweep_word got=%h expected=%h", d, t); end
`endif
         if (c == 8) begin
            if (n8 == 0) first8 = d;
            else if (d != first8) distinct = 1'b1;
            n8++;
         end
      end
`ifdef BIT_POP_GEN_RANDOM_EN
      checks++;
      if (distinct !== 1'b1) begin errors++; $display("FAIL sweep_distinct_cnt8 got=%b expected=1", distinct); end
`endif
   endtask

   task automatic test_repeatability();
      int          seq[6];
      logic [15:0] run_a[6];
      logic [15:0] d;
      int          lat;
      logic        dva;
      seq = '{8, 3, 16, 8, 11, 1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req16(seq[i], d, lat, dva);
         run_a[i] = d;
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req16(seq[i], d, lat, dva);
         checks++;
         if (d !== run_a[i]) begin
            errors++; $display("FAIL repeat_word idx=%0d got=%h expected=%h", i, d, run_a[i]);
         end
      end
   endtask

   initial begin
      srst  = 1'b1;
      val8  = 1'b0;
      val16 = 1'b0;
      cnt8  = '0;
      cnt16 = '0;
      test_reset();
      test_latency();
      test_clamp();
      test_back_to_back();
      test_reset_mid_fill();
      test_sweep16();
      test_repeatability();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
